// File: rtl/rs_dispatch_arbiter.sv
// Round-robin dispatch arbiter: several reservation stations share one execution
// lane through a single registered output stage with valid/ready handshaking.
module rs_dispatch_arbiter #(
    parameter int XLEN                = 64,
    parameter int NUM_RS              = 4,
    parameter int ROB_INDEX_WIDTH     = 8,
    parameter int DECODED_INSTR_WIDTH = 32
) (
    input  logic                                  clock_i,
    input  logic                                  reset_i,
    input  logic [NUM_RS-1:0]                     rs_valid_i,
    output logic [NUM_RS-1:0]                     rs_ready_o,
    input  logic [NUM_RS*XLEN-1:0]                rs_1st_reg_i,
    input  logic [NUM_RS*XLEN-1:0]                rs_2nd_reg_i,
    input  logic [NUM_RS*XLEN-1:0]                rs_address_i,
    input  logic [NUM_RS*DECODED_INSTR_WIDTH-1:0] rs_decoded_instruction_i,
    input  logic [NUM_RS*ROB_INDEX_WIDTH-1:0]     rs_ROB_destination_i,
    input  logic                                  lane_ready_i,
    output logic                                  lane_valid_o,
    output logic [XLEN-1:0]                       lane_1st_reg_o,
    output logic [XLEN-1:0]                       lane_2nd_reg_o,
    output logic [XLEN-1:0]                       lane_address_o,
    output logic [DECODED_INSTR_WIDTH-1:0]        lane_decoded_instruction_o,
    output logic [ROB_INDEX_WIDTH-1:0]            lane_ROB_destination_o,
    output logic [$clog2(NUM_RS)-1:0]             lane_source_o,
    input  logic                                  flush_i
);

    localparam int IDX_W = $clog2(NUM_RS);
    localparam logic [IDX_W:0] NUM_RS_W = (IDX_W + 1)'(NUM_RS);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   cand;
    logic [NUM_RS-1:0] grant;
    logic             found;
    logic             load_en;
    logic             arb_ok;
    logic             any_grant;

    assign load_en = !lane_valid_o || lane_ready_i;
    // Holding reset low also blocks the handshake, so nothing leaks out mid-reset.
    assign arb_ok  = load_en && !flush_i && reset_i;

    // NOTE: combinational temporaries use blocking '=' and get a default before any
    // branch, so every path assigns them and no latch is inferred.
    always_comb begin
        cand      = '0;
        grant_idx = '0;
        found     = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= NUM_RS_W) cand = cand - NUM_RS_W;
            if (!found && rs_valid_i[cand[IDX_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
        if (arb_ok && found) grant[grant_idx] = 1'b1;
    end

    assign rs_ready_o = grant;
    assign any_grant  = |grant;
    assign ptr_next   = (grant_idx == IDX_W'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    // The payload is reset as well because its zero value is observable on the lane.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr                        <= '0;
            lane_valid_o               <= 1'b0;
            lane_source_o              <= '0;
            lane_1st_reg_o             <= '0;
            lane_2nd_reg_o             <= '0;
            lane_address_o             <= '0;
            lane_decoded_instruction_o <= '0;
            lane_ROB_destination_o     <= '0;
        end else if (flush_i) begin
            lane_valid_o <= 1'b0;
        end else if (load_en) begin
            lane_valid_o <= any_grant;
            if (any_grant) begin
                ptr                        <= ptr_next;
                lane_source_o              <= grant_idx;
                lane_1st_reg_o             <= rs_1st_reg_i[int'(grant_idx)*XLEN +: XLEN];
                lane_2nd_reg_o             <= rs_2nd_reg_i[int'(grant_idx)*XLEN +: XLEN];
                lane_address_o             <= rs_address_i[int'(grant_idx)*XLEN +: XLEN];
                lane_decoded_instruction_o <=
                    rs_decoded_instruction_i[int'(grant_idx)*DECODED_INSTR_WIDTH +: DECODED_INSTR_WIDTH];
                lane_ROB_destination_o     <=
                    rs_ROB_destination_i[int'(grant_idx)*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_rs_dispatch_arbiter.sv
// Directed bench for rs_dispatch_arbiter: a table of per-cycle vectors plus
// hand-written backpressure and asynchronous-reset sequences.
module tb_rs_dispatch_arbiter;

    localparam int XLEN = 64;
    localparam int NRS  = 4;
    localparam int ROBW = 8;
    localparam int DECW = 32;

    logic                 clock_i = 1'b0;
    logic                 reset_i;
    logic [NRS-1:0]       rs_valid_i;
    logic [NRS-1:0]       rs_ready_o;
    logic [NRS*XLEN-1:0]  rs_1st_reg_i, rs_2nd_reg_i, rs_address_i;
    logic [NRS*DECW-1:0]  rs_decoded_instruction_i;
    logic [NRS*ROBW-1:0]  rs_ROB_destination_i;
    logic                 lane_ready_i;
    logic                 lane_valid_o;
    logic [XLEN-1:0]      lane_1st_reg_o, lane_2nd_reg_o, lane_address_o;
    logic [DECW-1:0]      lane_decoded_instruction_o;
    logic [ROBW-1:0]      lane_ROB_destination_o;
    logic [1:0]           lane_source_o;
    logic                 flush_i;

    rs_dispatch_arbiter #(
        .XLEN(XLEN), .NUM_RS(NRS), .ROB_INDEX_WIDTH(ROBW), .DECODED_INSTR_WIDTH(DECW)
    ) dut (
        .clock_i                    (clock_i),
        .reset_i                    (reset_i),
        .rs_valid_i                 (rs_valid_i),
        .rs_ready_o                 (rs_ready_o),
        .rs_1st_reg_i               (rs_1st_reg_i),
        .rs_2nd_reg_i               (rs_2nd_reg_i),
        .rs_address_i               (rs_address_i),
        .rs_decoded_instruction_i   (rs_decoded_instruction_i),
        .rs_ROB_destination_i       (rs_ROB_destination_i),
        .lane_ready_i               (lane_ready_i),
        .lane_valid_o               (lane_valid_o),
        .lane_1st_reg_o             (lane_1st_reg_o),
        .lane_2nd_reg_o             (lane_2nd_reg_o),
        .lane_address_o             (lane_address_o),
        .lane_decoded_instruction_o (lane_decoded_instruction_o),
        .lane_ROB_destination_o     (lane_ROB_destination_o),
        .lane_source_o              (lane_source_o),
        .flush_i                    (flush_i)
    );

    always #5 clock_i = ~clock_i;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       lrdy;
        logic       flush;
        logic [3:0] ready;
        logic       lv;
        logic [1:0] src;
        logic [7:0] rob;
    } vec_t;

    vec_t tbl[16];

    // Drive one cycle of inputs, check the combinational grant, then the registered lane.
    task automatic run_vec(input int n, input vec_t v);
        rs_valid_i   = v.valid;
        lane_ready_i = v.lrdy;
        flush_i      = v.flush;
        #1;
        check($sformatf("v%0d rs_ready", n), 64'(rs_ready_o), 64'(v.ready));
        @(posedge clock_i); #1;
        check($sformatf("v%0d lane_valid", n), 64'(lane_valid_o), 64'(v.lv));
        if (v.lv) begin
            check($sformatf("v%0d lane_source", n), 64'(lane_source_o), 64'(v.src));
            check($sformatf("v%0d lane_rob", n), 64'(lane_ROB_destination_o), 64'(v.rob));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i      = 1'b0;
        rs_valid_i   = '0;
        lane_ready_i = 1'b1;
        flush_i      = 1'b0;
        for (int i = 0; i < NRS; i++) begin
            rs_1st_reg_i[i*XLEN +: XLEN]             = 64'(10*i + 1);
            rs_2nd_reg_i[i*XLEN +: XLEN]             = 64'(10*i + 2);
            rs_address_i[i*XLEN +: XLEN]             = 64'(100 + i);
            rs_decoded_instruction_i[i*DECW +: DECW] = 32'(32'hD0 + i);
            rs_ROB_destination_i[i*ROBW +: ROBW]     = 8'(i + 1);
        end

        //               valid  lrdy  fl    ready   lv    src    rob
        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd1};
        tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd2};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd3};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd4};
        tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd1};
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0};
        tbl[7]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd3};
        tbl[8]  = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd4};
        tbl[9]  = '{4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd2};
        tbl[10] = '{4'b1010, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd2};
        tbl[11] = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd4};
        tbl[12] = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 8'd0};
        tbl[13] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd1};
        tbl[14] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'd1};
        tbl[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0};

        // Outputs while reset is held, even with a valid request present.
        rs_valid_i = 4'b0001;
        #12;
        check("reset rs_ready", 64'(rs_ready_o), 64'd0);
        check("reset lane_valid", 64'(lane_valid_o), 64'd0);
        check("reset lane_source", 64'(lane_source_o), 64'd0);
        check("reset lane_1st", lane_1st_reg_o, 64'd0);
        rs_valid_i = '0;
        reset_i    = 1'b1;
        @(posedge clock_i); #1;

        for (int n = 0; n < 16; n++) run_vec(n, tbl[n]);

        // Held output under backpressure: ptr=1, lane empty, RS2 carries ROB 2.
        rs_ROB_destination_i[2*ROBW +: ROBW] = 8'd2;
        rs_valid_i   = 4'b0100;
        lane_ready_i = 1'b0;
        #1;
        check("hold grant", 64'(rs_ready_o), 64'b0100);
        @(posedge clock_i); #1;
        check("hold addr", lane_address_o, 64'd102);
        check("hold decoded", 64'(lane_decoded_instruction_o), 64'hD2);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("hold%0d rs_ready", c), 64'(rs_ready_o), 64'd0);
            @(posedge clock_i); #1;
            check($sformatf("hold%0d lane_valid", c), 64'(lane_valid_o), 64'd1);
            check($sformatf("hold%0d 1st", c), lane_1st_reg_o, 64'd21);
            check($sformatf("hold%0d 2nd", c), lane_2nd_reg_o, 64'd22);
            check($sformatf("hold%0d rob", c), 64'(lane_ROB_destination_o), 64'd2);
        end
        rs_valid_i   = 4'b0000;
        lane_ready_i = 1'b1;
        @(posedge clock_i); #1;
        check("drain lane_valid", 64'(lane_valid_o), 64'd0);

        // Async reset mid-cycle with an instruction held: ptr=3, RS0 wins.
        rs_valid_i   = 4'b0001;
        lane_ready_i = 1'b0;
        @(posedge clock_i); #1;
        check("pre-reset lane_valid", 64'(lane_valid_o), 64'd1);
        check("pre-reset source", 64'(lane_source_o), 64'd0);
        #2;
        reset_i = 1'b0;
        #1;
        check("async lane_valid", 64'(lane_valid_o), 64'd0);
        check("async rs_ready", 64'(rs_ready_o), 64'd0);
        check("async rob", 64'(lane_ROB_destination_o), 64'd0);
        check("async 1st", lane_1st_reg_o, 64'd0);
        lane_ready_i = 1'b1;
        @(posedge clock_i); #1;
        check("in-reset lane_valid", 64'(lane_valid_o), 64'd0);
        #3;
        reset_i = 1'b1;
        #1;
        check("post-reset grant", 64'(rs_ready_o), 64'b0001);
        @(posedge clock_i); #1;
        check("post-reset lane_valid", 64'(lane_valid_o), 64'd1);
        check("post-reset rob", 64'(lane_ROB_destination_o), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rs_dispatch_arbiter.md
RS_DISPATCH_ARBITER -- requirements
Module: rs_dispatch_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, register/operand width.
REQ-002 SHALL have parameter NUM_RS, default 4, number of reservation stations sharing one execution lane; legal range 2..8.
REQ-003 SHALL have parameter ROB_INDEX_WIDTH, default 8, ROB index width.
REQ-004 SHALL have parameter DECODED_INSTR_WIDTH, default 32, decoded instruction width.
REQ-005 SHALL have port clock_i, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rs_valid_i, input, NUM_RS, per-RS dispatch-valid.
REQ-008 SHALL have port rs_ready_o, output, NUM_RS, per-RS dispatch-ready (the grant).
REQ-009 SHALL have ports rs_1st_reg_i, rs_2nd_reg_i, rs_address_i, input, NUM_RS*XLEN each, packed operands/address; RS i occupies bits [i*XLEN +: XLEN].
REQ-010 SHALL have port rs_decoded_instruction_i, input, NUM_RS*DECODED_INSTR_WIDTH, packed per RS.
REQ-011 SHALL have port rs_ROB_destination_i, input, NUM_RS*ROB_INDEX_WIDTH, packed per RS.
REQ-012 SHALL have port lane_ready_i, input, 1, execution lane accepts.
REQ-013 SHALL have port lane_valid_o, output, 1, output register holds an instruction.
REQ-014 SHALL have ports lane_1st_reg_o, lane_2nd_reg_o, lane_address_o (XLEN), lane_decoded_instruction_o (DECODED_INSTR_WIDTH), lane_ROB_destination_o (ROB_INDEX_WIDTH), output, registered payload.
REQ-015 SHALL have port lane_source_o, output, clog2(NUM_RS), index of RS that supplied the held instruction.
REQ-016 SHALL have port flush_i, input, 1, pipeline flush.

Function
REQ-017 SHALL hold one output register (lane_valid_o plus payload plus source); load_en = !lane_valid_o | lane_ready_i.
REQ-018 SHALL grant at most one RS per cycle; grant only when load_en=1, flush_i=0, and that RS's rs_valid_i=1; rs_ready_o is a combinational function of rs_valid_i, load_en, flush_i, and the priority pointer.
REQ-019 SHALL use round-robin priority: search starts at pointer ptr and proceeds ptr, ptr+1, ..., wrapping modulo NUM_RS; first valid RS wins.
REQ-020 SHALL, on a grant to RS g, set ptr to (g+1) mod NUM_RS at the next edge; ptr is unchanged when there is no grant.
REQ-021 SHALL, on a grant, load the granted RS's payload and set lane_source_o=g and lane_valid_o=1 at the next edge: latency from handshake to lane_valid_o is 1 cycle.
REQ-022 SHALL, when lane_valid_o=1, lane_ready_i=1, and no grant, clear lane_valid_o at the next edge.
REQ-023 SHALL sustain one instruction per cycle when lane_ready_i stays 1 (simultaneous drain and load).
REQ-024 SHALL keep payload and lane_valid_o stable while lane_valid_o=1 and lane_ready_i=0.
REQ-025 SHALL, when flush_i=1, drive rs_ready_o=0 and clear lane_valid_o at the next edge, regardless of lane_ready_i; ptr is unchanged.
REQ-026 SHALL never drive a ready to an RS whose rs_valid_i=0.

Reset
REQ-027 SHALL, on reset_i=0, immediately clear lane_valid_o, set ptr=0, set lane_source_o=0, and zero all lane payload outputs.
REQ-028 SHALL drive rs_ready_o=0 while reset_i=0; an instruction held mid-operation is discarded, not dispatched.
REQ-029 SHALL resume arbitration on the first rising edge after reset_i returns to 1.

Verification
REQ-030 Reset release with lane_ready_i=1, no valids -> lane_valid_o=0, rs_ready_o=0, ptr=0.
REQ-031 RS0..RS3 all valid with ROB 1,2,3,4, lane_ready_i=1 held -> grants RS0,RS1,RS2,RS3,RS0 on consecutive cycles; lane_ROB_destination_o is 1,2,3,4 one cycle after each grant.
REQ-032 RS2 valid (1st=21, 2nd=22, ROB=2), lane_ready_i=0 for 5 cycles -> one grant, then rs_ready_o=0 while held; output steady at 21/22/2 until lane_ready_i=1, then lane_valid_o drops the next cycle if no other valid.
REQ-033 ptr=3 with RS1 and RS3 valid -> RS3 granted first, ptr wraps to 0, RS1 granted next.
REQ-034 lane_valid_o=1 with flush_i=1 and RS0 valid -> rs_ready_o=0 that cycle; lane_valid_o=0 next cycle; RS0 granted the cycle after flush_i drops.
REQ-035 reset_i asserted asynchronously mid-cycle while lane_valid_o=1 -> lane_valid_o=0 before the next edge; no dispatch observed.
